// File: rtl/serial_sub.sv
// serial_sub: multi-cycle subtractor computing a - b - bin, CHUNK bits per clock.
// Operands are latched into shift registers on acceptance. Each RUN cycle consumes the
// low CHUNK bits through a chained full-subtract slice and shifts the partial difference
// into the top of a result register. The borrow is carried between cycles in br_q.
// Result outputs update only on the completion edge and on reset.
module serial_sub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic             sat_en,
    input  logic             out_ack,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int unsigned NumChunks = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
    localparam int unsigned CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NumChunks - 1);

    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("serial_sub: CHUNK must be >= 1 and divide WIDTH (WIDTH >= 1)");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             sat_q, sat_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;

    logic [CHUNK-1:0] d_slice;
    logic             br_next;
    logic [WIDTH-1:0] res_shift;

    // Chained full-subtract over the current low CHUNK bits of the operand shift registers
    always_comb begin
        logic br_walk;
        logic x;
        logic y;
        br_walk = br_q;
        d_slice = '0;
        for (int i = 0; i < int'(CHUNK); i++) begin
            x          = a_q[i];
            y          = b_q[i];
            d_slice[i] = x ^ y ^ br_walk;
            br_walk    = (~x & y) | (~(x ^ y) & br_walk);
        end
        br_next = br_walk;
    end

    // New slice enters at the top so the first slice ends up in the LSBs after NumChunks shifts
    always_comb begin
        res_shift = (res_q >> CHUNK) | (WIDTH'(d_slice) << (WIDTH - CHUNK));
    end

    // Next-state: handshake FSM, datapath shifting and completion-edge output update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        sat_d    = sat_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    sat_d   = sat_en;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d   = a_q >> CHUNK;
                b_d   = b_q >> CHUNK;
                res_d = res_shift;
                br_d  = br_next;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    cnt_d    = '0;
                    state_d  = StDone;
                    // Unsigned clamp: a negative result saturates to zero, borrow still reported
                    diff_d   = (sat_q && br_next) ? '0 : res_shift;
                    borrow_d = br_next;
                    zero_d   = (diff_d == '0);
                end
            end
            StDone: begin
                if (out_ack) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            sat_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            sat_q    <= sat_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
        end
    end

    // Status decoded from state so reset clears it without waiting for a clock edge
    always_comb begin
        in_ready = (state_q == StIdle);
        busy     = (state_q == StRun);
        done     = (state_q == StDone);
        diff     = diff_q;
        borrow   = borrow_q;
        zero     = zero_q;
    end

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: three instances (8/1, 8/4, 1/1) share one stimulus stream.
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       sat_en;
    logic       out_ack;

    logic       rdy8, busy8, done8, bo8, z8;
    logic [7:0] diff8;
    logic       rdyc, busyc, donec, boc, zc;
    logic [7:0] diffc;
    logic       rdy1, busy1, done1, bo1, z1;
    logic [0:0] diff1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(8), .CHUNK(1)) u_s8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin), .sat_en(sat_en),
        .out_ack(out_ack), .in_ready(rdy8), .busy(busy8), .done(done8), .diff(diff8),
        .borrow(bo8), .zero(z8)
    );

    serial_sub #(.WIDTH(8), .CHUNK(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin), .sat_en(sat_en),
        .out_ack(out_ack), .in_ready(rdyc), .busy(busyc), .done(donec), .diff(diffc),
        .borrow(boc), .zero(zc)
    );

    serial_sub #(.WIDTH(1), .CHUNK(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a[0:0]), .b(b[0:0]), .bin(bin),
        .sat_en(sat_en), .out_ack(out_ack), .in_ready(rdy1), .busy(busy1), .done(done1),
        .diff(diff1), .borrow(bo1), .zero(z1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic       sat;
        logic [7:0] ed8;
        logic       eb8;
        logic       ed1;
        logic       eb1;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer subtraction on w bits, clamp negative results when sat is set
    task automatic ref_sub(input int w, input logic [7:0] ra, input logic [7:0] rb,
                           input logic rbin, input logic rsat,
                           output logic [7:0] d, output logic bo);
        longint mask;
        longint full;
        mask = (longint'(1) << w) - 1;
        full = (longint'(ra) & mask) - (longint'(rb) & mask) - longint'(rbin);
        bo   = (full < 0);
        d    = 8'(full & mask);
        if (rsat && bo) d = 8'h00;
    endtask

    // One transaction on all three instances; optional scrambling of inputs while busy
    task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                         input logic tbin, input logic tsat, input bit scramble,
                         input logic [7:0] e8d, input logic e8b,
                         input logic e1d, input logic e1b);
        int l8, lc, l1, n8, nc, n1;
        l8 = -1; lc = -1; l1 = -1;
        n8 = 0; nc = 0; n1 = 0;
        @(negedge clk);
        a = ta; b = tb; bin = tbin; sat_en = tsat; start = 1'b1; out_ack = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " busy_after_accept"}, {busy8, busyc, busy1}, 3'b111);
        chk({tag, " rdy_after_accept"}, {rdy8, rdyc, rdy1}, 3'b000);
        if (busy8) n8++;
        if (busyc) nc++;
        if (busy1) n1++;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (scramble) begin
                a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom); sat_en = 1'($urandom);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done8 && l8 < 0) l8 = k;
            if (donec && lc < 0) lc = k;
            if (done1 && l1 < 0) l1 = k;
            if (busy8) n8++;
            if (busyc) nc++;
            if (busy1) n1++;
        end
        chk({tag, " lat8"}, 64'(l8), 64'd8);
        chk({tag, " latc4"}, 64'(lc), 64'd2);
        chk({tag, " lat1"}, 64'(l1), 64'd1);
        chk({tag, " busy_cycles"}, {32'(n8), 16'(nc), 16'(n1)}, {32'd8, 16'd2, 16'd1});
        chk({tag, " done_held"}, {done8, donec, done1}, 3'b111);
        chk({tag, " diff8"}, diff8, e8d);
        chk({tag, " borrow8"}, bo8, e8b);
        chk({tag, " zero8"}, z8, (e8d == 8'h00));
        chk({tag, " diffc4"}, diffc, e8d);
        chk({tag, " borrowc4"}, boc, e8b);
        chk({tag, " zeroc4"}, zc, (e8d == 8'h00));
        chk({tag, " diff1"}, diff1, e1d);
        chk({tag, " borrow1"}, bo1, e1b);
        chk({tag, " zero1"}, z1, (e1d == 1'b0));
        // Ack with start high: start must be ignored on the ack edge
        @(negedge clk);
        out_ack = 1'b1; start = 1'b1; a = ~ta;
        @(posedge clk);
        #1;
        chk({tag, " rdy_after_ack"}, {rdy8, rdyc, rdy1}, 3'b111);
        chk({tag, " busy_after_ack"}, {busy8, busyc, busy1, done8, donec, done1}, 6'b0);
        chk({tag, " diff8_hold_idle"}, diff8, e8d);
        @(negedge clk);
        out_ack = 1'b0; start = 1'b0;
    endtask

    initial begin
        logic [7:0] r8d;
        logic [7:0] r1d;
        logic       r8b;
        logic       r1b;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbin;
        logic       rsat;

        //            a      b      bin   sat   ed8    eb8   ed1   eb1
        vecs[0]  = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h1E, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{8'h10, 8'h20, 1'b0, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{8'h10, 8'h20, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{8'h37, 8'h36, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{8'hA5, 8'h5A, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{8'h00, 8'h01, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{8'h00, 8'h01, 1'b1, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{8'h01, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{8'h01, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{8'h01, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{8'h01, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1};
        vecs[14] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0; sat_en = 1'b0; out_ack = 1'b0;
        #2;
        chk("reset_status", {rdy8, busy8, done8, rdyc, busyc, donec, rdy1, busy1, done1},
            9'b100_100_100);
        chk("reset_results", {diff8, bo8, z8, diffc, boc, zc, diff1, bo1, z1}, 21'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].sat,
                  (i % 3) == 1, vecs[i].ed8, vecs[i].eb8, vecs[i].ed1, vecs[i].eb1);
        end

        // Reset in the middle of RUN after a nonzero result is on the outputs
        do_op("pre_reset", 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h1E, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        a = 8'hC3; b = 8'h11; bin = 1'b0; sat_en = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        chk("pre_reset_busy8", busy8, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_status", {rdy8, busy8, done8, rdyc, busyc, donec, rdy1, busy1, done1},
            9'b100_100_100);
        chk("async_reset_diff8", diff8, 8'h00);
        chk("async_reset_flags", {bo8, z8, diffc, boc, zc, diff1, bo1, z1}, 13'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("post_reset", 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Randomized transactions against the arithmetic reference
        for (int i = 0; i < 40; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            rsat = 1'($urandom);
            ref_sub(8, ra, rb, rbin, rsat, r8d, r8b);
            ref_sub(1, ra, rb, rbin, rsat, r1d, r1b);
            do_op($sformatf("rnd%0d", i), ra, rb, rbin, rsat, 1'($urandom), r8d, r8b,
                  r1d[0], r1b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
